// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the serial-to-parallel framer:
//   - state_e        : framer FSM states (PAR is used only when the
//                      SIPO_PARITY_EN macro is defined)
//   - DATA_W_DEFAULT : default payload width
//   - START_BIT      : line level that opens a frame
//   - STOP_BIT       : line level that closes a good frame
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam int   DATA_W_DEFAULT = 8;
    localparam logic START_BIT      = 1'b1;
    localparam logic STOP_BIT       = 1'b0;

endpackage : sipo_pkg

// File: rtl/sipo_out_buf.sv
// -----------------------------------------------------------------------------
// sipo_out_buf
// One-entry valid/ready holding register for assembled words, with a sticky
// overrun flag for words that arrive while the entry is still occupied.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   load_i     in   a good word is offered this edge
//   din_i      in   word offered with load_i
//   rdy_i      in   consumer takes dout_o on an edge where dvalid_o && rdy_i
//   dout_o     out  last accepted word (held after handoff)
//   dvalid_o   out  dout_o holds an unconsumed word
//   overrun_o  out  sticky: a word was dropped because the entry was full
// -----------------------------------------------------------------------------
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              rdy_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dvalid_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              overrun_q, overrun_d;
    logic              drain;

    // rdy_i is only meaningful while a word is held.
    assign drain = dvalid_q && rdy_i;

    always_comb begin
        dout_d    = dout_q;
        dvalid_d  = dvalid_q;
        overrun_d = overrun_q;
        if (load_i && (!dvalid_q || drain)) begin
            // Empty, or emptying on this very edge: take the new word.
            dout_d   = din_i;
            dvalid_d = 1'b1;
        end else if (load_i) begin
            // Full and not draining: keep the old word, flag the loss.
            overrun_d = 1'b1;
        end else if (drain) begin
            dvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q    <= '0;
            dvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout_o    = dout_q;
    assign dvalid_o  = dvalid_q;
    assign overrun_o = overrun_q;

endmodule : sipo_out_buf

// File: rtl/sipo_framer.sv
// -----------------------------------------------------------------------------
// sipo_framer
// Serial-to-parallel framer. Finds frames on a synchronous single-bit stream
// (start 1, DATA_W data bits LSB first, optional even parity, stop 0),
// assembles the payload and hands it out through a one-entry valid/ready
// buffer.
//
// Optional feature: define SIPO_PARITY_EN to add the PAR state and check an
// even-parity bit (expected value ^data) before the stop bit.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   sin        in   serial input, idle level 0
//   dout       out  last accepted word, bit 0 = first data bit received
//   dvalid     out  dout holds an unconsumed word
//   dready     in   consumer accepts dout on an edge where dvalid && dready
//   busy       out  FSM is outside IDLE
//   frame_err  out  one-cycle pulse, the cycle after a frame is discarded
//   overrun    out  sticky; a good frame was dropped because dout was full
// -----------------------------------------------------------------------------
module sipo_framer
    import sipo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    input  logic              dready,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q;
    logic              frame_good;
    logic              frame_bad;
    logic              par_ok;
`ifdef SIPO_PARITY_EN
    logic              par_q, par_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
`ifdef SIPO_PARITY_EN
        par_d      = par_q;
        par_ok     = (par_q == ^shift_q);
`else
        par_ok     = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (sin == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                // Right shift, new bit enters at the MSB: after DATA_W bits
                // the first one received sits at bit 0.
                shift_d = {sin, shift_q[DATA_W-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
                    state_d = PAR;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef SIPO_PARITY_EN
            PAR: begin
                par_d   = sin;
                state_d = STOP;
            end
`endif
            STOP: begin
                if ((sin == STOP_BIT) && par_ok) begin
                    frame_good = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_bad;
`ifdef SIPO_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // The word is offered to the buffer on the stop-bit edge itself, so dout
    // and dvalid change on that edge.
    sipo_out_buf #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load_i    (frame_good),
        .din_i     (shift_q),
        .rdy_i     (dready),
        .dout_o    (dout),
        .dvalid_o  (dvalid),
        .overrun_o (overrun)
    );

    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule : sipo_framer

// File: tb/tb_sipo_framer.sv
// -----------------------------------------------------------------------------
// tb_sipo_framer
// Directed bench for sipo_framer with DATA_W = 8. Inputs change on the falling
// edge; outputs are sampled on the falling edge after the rising edge that
// consumed the bit. Define SIPO_PARITY_EN for both bench and RTL to exercise
// the parity build.
// -----------------------------------------------------------------------------
module tb_sipo_framer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         sin;
    logic [W-1:0] dout;
    logic         dvalid;
    logic         dready;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int errs   = 0;
    int checks = 0;

    sipo_framer #(
        .DATA_W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .dout      (dout),
        .dvalid    (dvalid),
        .dready    (dready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one bit; returns at the falling edge after it was sampled.
    task automatic bit_at(input logic b);
        sin = b;
        @(negedge clk);
    endtask

    // Full frame. If rdy_at_stop is set, dready is raised together with the
    // stop bit so it is seen on the stop edge.
    task automatic send_frame(input logic [W-1:0] d, input logic par,
                              input logic stop, input logic rdy_at_stop);
        bit_at(1'b1);
        for (int i = 0; i < W; i++) bit_at(d[i]);
`ifdef SIPO_PARITY_EN
        bit_at(par);
`else
        if (par) begin end
`endif
        if (rdy_at_stop) dready = 1'b1;
        bit_at(stop);
    endtask

    task automatic do_reset();
        sin = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_dout"},      32'(dout),      32'h0);
        check_val({tag, "_dvalid"},    32'(dvalid),    32'h0);
        check_val({tag, "_busy"},      32'(busy),      32'h0);
        check_val({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check_val({tag, "_overrun"},   32'(overrun),   32'h0);
    endtask

    initial begin
        rst    = 1'b0;
        sin    = 1'b0;
        dready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Reset in the middle of a frame, after 3 data bits.
        bit_at(1'b1);
        bit_at(1'b1);
        bit_at(1'b1);
        bit_at(1'b1);
        check_val("midframe_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        sin = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dready = 1'b1;
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
        check_val("after_midreset_dout",   32'(dout),   32'hB2);
        check_val("after_midreset_dvalid", 32'(dvalid), 32'h1);

        // Plain good frame with dready high; it drains one edge later.
        bit_at(1'b0);
        check_val("drain_dvalid", 32'(dvalid), 32'h0);
        check_val("drain_dout_hold", 32'(dout), 32'hB2);
        bit_at(1'b1);
        check_val("busy_rise", 32'(busy), 32'h1);
        for (int i = 0; i < W; i++) bit_at(i[0]);   // data 8'hAA
        bit_at(1'b0);
        check_val("good_dout",      32'(dout),      32'hAA);
        check_val("good_dvalid",    32'(dvalid),    32'h1);
        check_val("good_frame_err", 32'(frame_err), 32'h0);
        check_val("good_busy_fall", 32'(busy),      32'h0);

        // Bad stop bit: word discarded, one-cycle error pulse.
        bit_at(1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_val("badstop_frame_err", 32'(frame_err), 32'h1);
        check_val("badstop_dvalid",    32'(dvalid),    32'h0);
        check_val("badstop_dout",      32'(dout),      32'hAA);
        bit_at(1'b0);
        check_val("badstop_pulse_end", 32'(frame_err), 32'h0);
        check_val("badstop_idle",      32'(busy),      32'h0);

        // Back-to-back frames into a full buffer.
        do_reset();
        dready = 1'b0;
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
        check_val("b2b_first_dout",   32'(dout),   32'hB2);
        check_val("b2b_first_dvalid", 32'(dvalid), 32'h1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check_val("b2b_full_dout",    32'(dout),    32'hB2);
        check_val("b2b_full_dvalid",  32'(dvalid),  32'h1);
        check_val("b2b_full_overrun", 32'(overrun), 32'h1);
        bit_at(1'b0);
        check_val("overrun_sticky", 32'(overrun), 32'h1);

        // Same pair, consumer drains on the second stop edge.
        do_reset();
        dready = 1'b0;
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check_val("b2b_drain_dout",    32'(dout),    32'h5A);
        check_val("b2b_drain_dvalid",  32'(dvalid),  32'h1);
        check_val("b2b_drain_overrun", 32'(overrun), 32'h0);
        dready = 1'b0;
        bit_at(1'b0);

`ifdef SIPO_PARITY_EN
        // Even parity: ^8'hB2 = 0.
        do_reset();
        dready = 1'b1;
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0);
        check_val("par_ok_dout",      32'(dout),      32'hB2);
        check_val("par_ok_dvalid",    32'(dvalid),    32'h1);
        check_val("par_ok_frame_err", 32'(frame_err), 32'h0);
        bit_at(1'b0);
        send_frame(8'hB2, 1'b1, 1'b0, 1'b0);
        check_val("par_bad_frame_err", 32'(frame_err), 32'h1);
        check_val("par_bad_dvalid",    32'(dvalid),    32'h0);
        bit_at(1'b0);
        check_val("par_bad_pulse_end", 32'(frame_err), 32'h0);
`endif

        // Long idle line.
        dready = 1'b1;
        bit_at(1'b0);
        for (int i = 0; i < 50; i++) begin
            bit_at(1'b0);
            check_val("idle_busy",      32'(busy),      32'h0);
            check_val("idle_dvalid",    32'(dvalid),    32'h0);
            check_val("idle_frame_err", 32'(frame_err), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_sipo_framer

// File: doc/sipo_framer.md
# sipo_framer

Serial-to-parallel framer placed directly downstream of the `siso` shift register. It consumes the single-bit serial stream from `siso`'s `sout`, finds framed words, assembles each into a DATA_W-bit word, and presents it through a one-entry valid/ready output buffer. It also flags framing errors and buffer overruns.

## Interface
- DATA_W, 8, payload bits per frame; legal range 2..32
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- sin  in  1  serial input, driven from `siso` `sout`; idle level 0
- dout  out  DATA_W  last accepted word, LSB = first data bit received
- dvalid  out  1  dout holds an unconsumed word
- dready  in  1  consumer accepts dout on an edge where dvalid && dready
- busy  out  1  FSM is outside IDLE
- frame_err  out  1  one-cycle pulse when a frame is discarded
- overrun  out  1  sticky; a good frame was dropped because the buffer was full

## Operation
- Frame format: start bit 1, DATA_W data bits LSB first, optional even-parity bit (see Configuration), stop bit 0.
- sin is sampled once per rising edge. There is no oversampling and no synchronizer; the upstream stage is synchronous to clk.
- FSM states are IDLE, DATA, PAR, STOP. PAR exists only with the macro.
- IDLE: if sin==1, go to DATA and clear bit count. If sin==0, stay in IDLE.
- DATA: shift sin into the shift register MSB side, right-shift, so the first bit ends at bit 0. Increment the count. After DATA_W bits, go to PAR, or to STOP when parity is compiled out.
- PAR: capture the parity bit, then go to STOP.
- STOP:
  - If sin==0 and parity is OK, the frame is good.
  - Otherwise discard the frame and pulse frame_err for 1 cycle.
  - Always go to IDLE. A new start bit is recognised on the very next edge.
- Bit counter width: $clog2(DATA_W+1). It has no wrap-around beyond DATA_W.
- Output buffer behaviour on a good frame:
  - Buffer empty, or draining the same edge (dvalid && dready): load dout and set dvalid.
  - Buffer full and not draining: drop the new word, keep old dout, set overrun.
- dready with dvalid==0 is ignored. dout holds its value after handoff until the next load.
- overrun clears only on reset.
- Reset (at any time, including mid-frame): FSM goes to IDLE, count=0, shift register=0. Reset value of every output is 0: dout=0, dvalid=0, busy=0, frame_err=0, overrun=0.

## Timing
- Start bit sampled at edge t0. Data bits at t0+1..t0+DATA_W. Parity at t0+DATA_W+1 when enabled. Stop bit at edge ts = t0+DATA_W+1, or +2 with parity.
- dvalid and dout update on edge ts. frame_err is high for the cycle after ts.
- busy rises after t0 and falls after ts.
- Back-to-back frames: the next start bit can arrive at ts+1.
- Minimum frame period: DATA_W+2 cycles, or DATA_W+3 with parity.

## Configuration
- SIPO_PARITY_EN defined: include the PAR state and even parity. The expected bit is ^data. A mismatch discards the frame and pulses frame_err, exactly as a bad stop bit does.
- SIPO_PARITY_EN undefined: no PAR state and no parity logic. The frame is start + DATA_W data + stop.

## Structure
- Package sipo_pkg holds:
  - state enum typedef (IDLE, DATA, PAR, STOP)
  - DATA_W_DEFAULT constant
  - START_BIT=1, STOP_BIT=0 constants
- Sub-module sipo_out_buf: one-entry valid/ready holding register with the overrun logic. It is instantiated once by sipo_framer.

## Test plan
- Reset asserted mid-frame after 3 data bits, then released: all outputs 0, FSM in IDLE, next full frame received correctly.
- DATA_W=8, parity off. sin = 1, 0,1,0,0,1,1,0,1, 0 with dready=1: dout=8'hB2 and dvalid=1 at the stop edge; no frame_err.
- Same frame but stop bit 1: frame_err pulses 1 cycle, dvalid stays 0, dout unchanged.
- Two back-to-back good frames 8'hB2 then 8'h5A with dready=0: dout stays 8'hB2 and overrun=1. Raise dready on the second stop edge instead: dout=8'h5A, dvalid=1, overrun=0.
- SIPO_PARITY_EN: 8'hB2 with parity 0 is accepted. With parity 1, frame_err pulses and the word is dropped.
- sin held 0 for 50 cycles: busy=0, dvalid=0, no error pulses.
